// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, flit/port/state encodings and XY routing.
package noc_pkg;

   typedef enum logic [1:0] {
      FT_HEAD   = 2'b00,
      FT_BODY   = 2'b01,
      FT_TAIL   = 2'b10,
      FT_SINGLE = 2'b11
   } flit_type_t;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      EAST  = 3'd2,
      SOUTH = 3'd3,
      WEST  = 3'd4
   } port_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUTE  = 2'd1,
      ACTIVE = 2'd2
   } ibuf_state_t;

   localparam int FLIT_TYPE_MSB = 33;
   localparam int FLIT_TYPE_LSB = 32;
   localparam int DEST_X_MSB    = 7;
   localparam int DEST_X_LSB    = 4;
   localparam int DEST_Y_MSB    = 3;
   localparam int DEST_Y_LSB    = 0;

   // Dimension-order routing: resolve X completely before moving in Y.
   function automatic port_t xy_route(input logic [3:0] dest_x, input logic [3:0] dest_y,
                                      input logic [3:0] rx, input logic [3:0] ry);
      if (dest_x > rx)      return EAST;
      else if (dest_x < rx) return WEST;
      else if (dest_y > ry) return NORTH;
      else if (dest_y < ry) return SOUTH;
      else                  return LOCAL;
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module flit_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] front
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign front   = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/input_port_buffer.sv
// Router input port: flit FIFO, XY route of the head flit, allocator request/grant and credits.
// Optional INBUF_STATS_EN adds flit_count and stall_count outputs.
module input_port_buffer #(
   parameter int         DEPTH    = 4,
   parameter int         FLIT_W   = 34,
   parameter logic [3:0] ROUTER_X = 4'd0,
   parameter logic [3:0] ROUTER_Y = 4'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [FLIT_W-1:0] in_flit,
   output logic              credit_out,
   output logic              req,
   output logic [2:0]        dport,
   input  logic              grant,
   output logic              out_valid,
   output logic [FLIT_W-1:0] out_flit,
   output logic              overflow_err
`ifdef INBUF_STATS_EN
   ,
   output logic [31:0]       flit_count,
   output logic [31:0]       stall_count
`endif
);
   import noc_pkg::*;

   ibuf_state_t       state_reg;
   port_t             dport_reg;
   logic              out_valid_reg;
   logic [FLIT_W-1:0] out_flit_reg;
   logic              credit_reg;
   logic              overflow_reg;

   logic              fifo_full;
   logic              fifo_empty;
   logic [FLIT_W-1:0] front;
   flit_type_t        front_type;
   logic              front_is_head;
   logic              front_is_tail;
   logic              req_int;
   logic              grant_pop;
   logic              pop;

   flit_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop),
      .din   (in_flit),
      .full  (fifo_full),
      .empty (fifo_empty),
      .front (front)
   );

   // Stray BODY/TAIL flits reaching the front while idle are dropped but still return a credit.
   always_comb begin
      front_type    = flit_type_t'(front[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
      front_is_head = (front_type == FT_HEAD) || (front_type == FT_SINGLE);
      front_is_tail = (front_type == FT_TAIL) || (front_type == FT_SINGLE);
      req_int       = (state_reg == ACTIVE) && !fifo_empty;
      grant_pop     = req_int && grant;
      pop           = grant_pop || ((state_reg == IDLE) && !fifo_empty && !front_is_head);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         dport_reg     <= LOCAL;
         out_valid_reg <= 1'b0;
         out_flit_reg  <= '0;
         credit_reg    <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         out_valid_reg <= grant_pop;
         credit_reg    <= pop;
         if (grant_pop) out_flit_reg <= front;
         if (in_valid && fifo_full && !pop) overflow_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (!fifo_empty && front_is_head) state_reg <= ROUTE;
            end
            ROUTE: begin
               dport_reg <= xy_route(front[DEST_X_MSB:DEST_X_LSB], front[DEST_Y_MSB:DEST_Y_LSB],
                                     ROUTER_X, ROUTER_Y);
               state_reg <= ACTIVE;
            end
            ACTIVE: begin
               if (grant_pop && front_is_tail) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req          = req_int;
   assign dport        = dport_reg;
   assign out_valid    = out_valid_reg;
   assign out_flit     = out_flit_reg;
   assign credit_out   = credit_reg;
   assign overflow_err = overflow_reg;

`ifdef INBUF_STATS_EN
   logic [31:0] flit_count_reg;
   logic [31:0] stall_count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         flit_count_reg  <= '0;
         stall_count_reg <= '0;
      end else begin
         if (pop) flit_count_reg <= flit_count_reg + 32'd1;
         if (req_int && !grant) stall_count_reg <= stall_count_reg + 32'd1;
      end
   end

   assign flit_count  = flit_count_reg;
   assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// Randomized scoreboard bench for input_port_buffer (router at (1,1), DEPTH 4).
module tb_input_port_buffer;
   localparam int DEPTH = 4;
   localparam int RX = 1;
   localparam int RY = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [33:0] in_flit;
   logic        credit_out;
   logic        req;
   logic [2:0]  dport;
   logic        grant;
   logic        out_valid;
   logic [33:0] out_flit;
   logic        overflow_err;
`ifdef INBUF_STATS_EN
   logic [31:0] flit_count;
   logic [31:0] stall_count;
`endif

   input_port_buffer #(.DEPTH(DEPTH), .FLIT_W(34), .ROUTER_X(4'd1), .ROUTER_Y(4'd1)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_flit      (in_flit),
      .credit_out   (credit_out),
      .req          (req),
      .dport        (dport),
      .grant        (grant),
      .out_valid    (out_valid),
      .out_flit     (out_flit),
      .overflow_err (overflow_err)
`ifdef INBUF_STATS_EN
      ,
      .flit_count   (flit_count),
      .stall_count  (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passes = 0;
   int          credit_cnt = 0;
   int          exp_credits = 0;
   logic [33:0] exp_q[$];
   logic [33:0] mq[$];
   logic        m_active = 1'b0;
   logic [33:0] mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [33:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                      input logic [3:0] dy, input logic [23:0] tag);
      return {t, tag, dx, dy};
   endfunction

   // Expected output port from the XY rule: signed offsets decide direction, X first.
   function automatic logic [2:0] ref_route(input logic [3:0] dx, input logic [3:0] dy);
      int ox, oy;
      ox = int'(dx) - RX;
      oy = int'(dy) - RY;
      if (ox > 0) return 3'd2;
      if (ox < 0) return 3'd4;
      if (oy > 0) return 3'd1;
      if (oy < 0) return 3'd3;
      return 3'd0;
   endfunction

   function automatic logic is_end(input logic [33:0] f);
      return f[33:32] == 2'b10 || f[33:32] == 2'b11;
   endfunction

   // One clock of stimulus plus the reference model's view of that clock.
   task automatic step(input logic v, input logic [33:0] f, input logic g);
      logic        full_m;
      logic        popped;
      logic [33:0] pf;
      in_valid = v;
      in_flit  = f;
      grant    = g;
      full_m   = (mq.size() == DEPTH);
      popped   = 1'b0;
      if (m_active && g && mq.size() > 0) begin
         pf = mq.pop_front();
         popped = 1'b1;
         exp_q.push_back(pf);
         exp_credits++;
         if (is_end(pf)) m_active = 1'b0;
      end else if (!m_active && mq.size() > 0 &&
                   (mq[0][33:32] == 2'b01 || mq[0][33:32] == 2'b10)) begin
         void'(mq.pop_front());
         popped = 1'b1;
         exp_credits++;
      end
      if (v && (!full_m || popped)) mq.push_back(f);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      grant    = 1'b0;
   endtask

   task automatic await_active(input int done);
      for (int i = done; i < 2; i++) begin
         chk("req_early", req, 0);
         step(1'b0, '0, 1'b0);
      end
      chk("req_latency", req, 1);
      m_active = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mq.delete();
      m_active = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (credit_out) credit_cnt++;
      if (out_valid) begin
         if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("out_flit", out_flit, mon_e);
            chk("credit_with_out", credit_out, 1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int          len, pushed, guard;
      logic [3:0]  dx, dy;
      logic [33:0] f;
      logic        v, g;

      rst = 1'b1; in_valid = 1'b0; in_flit = '0; grant = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_credit", credit_out, 0);
      chk("rst_dport", dport, 0);
      chk("rst_overflow", overflow_err, 0);
      rst = 1'b0;

      // SINGLE to (3,1): east
      step(1'b1, mk(2'b11, 4'd3, 4'd1, 24'h000a01), 1'b0);
      await_active(0);
      chk("t1_dport", dport, 2);
      step(1'b0, '0, 1'b1);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_req_after", req, 0);

      // stray BODY while idle is discarded with a credit
      step(1'b1, mk(2'b01, 4'd0, 4'd0, 24'h0000bb), 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("discard_credits", credit_cnt, exp_credits);

      // HEAD (1,0) south, BODY, TAIL with grant held
      step(1'b1, mk(2'b00, 4'd1, 4'd0, 24'h000b01), 1'b0);
      step(1'b1, mk(2'b01, 4'd9, 4'd9, 24'h000b02), 1'b0);
      step(1'b1, mk(2'b10, 4'd9, 4'd9, 24'h000b03), 1'b0);
      await_active(2);
      for (int i = 0; i < 3; i++) begin
         chk("t2_dport", dport, 3);
         step(1'b0, '0, 1'b1);
         chk("t2_out_valid", out_valid, 1);
      end
      chk("t2_req_idle", req, 0);

      // HEAD (0,1) west, FIFO drains mid-packet
      step(1'b1, mk(2'b00, 4'd0, 4'd1, 24'h000c01), 1'b0);
      await_active(0);
      chk("t3_dport", dport, 4);
      step(1'b0, '0, 1'b1);
      chk("t3_req_drop", req, 0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b1, mk(2'b01, 4'd7, 4'd7, 24'h000c02), 1'b0);
      chk("t3_req_again", req, 1);
      chk("t3_dport_held", dport, 4);
      step(1'b1, mk(2'b10, 4'd7, 4'd7, 24'h000c03), 1'b1);
      step(1'b0, '0, 1'b1);
      chk("t3_req_idle", req, 0);

      // overflow: five pushes into depth four, then push+pop while full
      step(1'b1, mk(2'b00, 4'd1, 4'd1, 24'h000d00), 1'b0);
      for (int i = 1; i <= 4; i++) step(1'b1, mk(2'b01, 4'd5, 4'd5, 24'(32'h000d00 + i)), 1'b0);
      chk("t4_overflow", overflow_err, 1);
      await_active(2);
      chk("t4_dport", dport, 0);
      step(1'b1, mk(2'b10, 4'd5, 4'd5, 24'h000d0f), 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      chk("t4_req_idle", req, 0);
      chk("t4_overflow_sticky", overflow_err, 1);

      // reset in the middle of a 3-flit packet
      step(1'b1, mk(2'b00, 4'd2, 4'd2, 24'h000e01), 1'b0);
      step(1'b1, mk(2'b01, 4'd2, 4'd2, 24'h000e02), 1'b0);
      step(1'b1, mk(2'b10, 4'd2, 4'd2, 24'h000e03), 1'b0);
      await_active(2);
      step(1'b0, '0, 1'b1);
      do_reset();
      chk("t5_req", req, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_dport", dport, 0);
      chk("t5_overflow", overflow_err, 0);
      step(1'b0, '0, 1'b0);
      chk("t5_empty", req, 0);
      step(1'b1, mk(2'b00, 4'd1, 4'd1, 24'h000e11), 1'b0);
      step(1'b1, mk(2'b10, 4'd1, 4'd1, 24'h000e12), 1'b0);
      await_active(1);
      chk("t5_dport_local", dport, 0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      chk("t5_req_idle", req, 0);

      // randomized well-formed packets with random grants
      for (int p = 0; p < 25; p++) begin
         len = $urandom_range(1, 4);
         dx  = 4'($urandom_range(0, 3));
         dy  = 4'($urandom_range(0, 3));
         step(1'b1, mk(len == 1 ? 2'b11 : 2'b00, dx, dy, 24'(p * 16)), 1'b0);
         await_active(0);
         pushed = 1;
         guard  = 0;
         while (m_active && guard < 200) begin
            chk("rnd_req", req, mq.size() > 0);
            chk("rnd_dport", dport, ref_route(dx, dy));
            v = (pushed < len) && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            f = mk(pushed == len - 1 ? 2'b10 : 2'b01, 4'($urandom), 4'($urandom),
                   24'(p * 16 + pushed));
            g = ($urandom_range(0, 2) != 0);
            step(v, f, g);
            if (v) pushed++;
            guard++;
         end
         if (guard >= 200) begin
            chk("rnd_pkt_timeout", 1, 0);
            do_reset();
         end
         chk("rnd_req_idle", req, 0);
      end

`ifdef INBUF_STATS_EN
      do_reset();
      step(1'b1, mk(2'b00, 4'd1, 4'd2, 24'h000f01), 1'b0);
      await_active(0);
      chk("t6_dport", dport, 1);
      repeat (5) step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("t6_stall_count", stall_count, 5);
      chk("t6_flit_count", flit_count, 1);
`endif

      repeat (3) step(1'b0, '0, 1'b0);
      chk("credit_total", credit_cnt, exp_credits);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
